// File: rtl/musa_pkg.sv
// Shared MUSA pipeline definitions: next-PC select codes, fetch FSM states and
// the bubble instruction word.
package musa_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_SRC_W = 3;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JREG   = 3'd3,
        PC_RET    = 3'd4
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Instruction fetches are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Call/return address LIFO with saturating depth and sticky overflow/underflow
// flags. An empty stack reports EMPTY_VAL as its top.
module return_stack #(
    parameter int unsigned           DEPTH     = 8,
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      EMPTY_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic             empty_c;
    logic             full_c;
    logic [PTR_W-1:0] top_idx_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CNT_W'(DEPTH));
    assign top_idx_c = PTR_W'(count - CNT_W'(1));
    assign top       = empty_c ? EMPTY_VAL : mem[top_idx_c];

    // Depth and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push && pop) begin
            if (empty_c) begin
                count     <= CNT_W'(1);
                underflow <= 1'b1;
            end
        end else if (push) begin
            if (full_c) begin
                overflow <= 1'b1;
            end else begin
                count <= CNT_W'(count + CNT_W'(1));
            end
        end else if (pop) begin
            if (empty_c) begin
                underflow <= 1'b1;
            end else begin
                count <= CNT_W'(count - CNT_W'(1));
            end
        end
    end

    // Push+pop overwrites the top in place; a push to a full stack is dropped.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            if (pop && !empty_c) begin
                mem[top_idx_c] <= din;
            end else if (!full_c) begin
                mem[PTR_W'(count)] <= din;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MUSA instruction-fetch stage: PC, request/ready fetch FSM, IF/ID register,
// next-PC redirect handling and the return-address stack.
module instruction_fetch
    import musa_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = musa_pkg::NOP_WORD,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic [2:0]      pc_src,
    input  logic [31:0]     branch_target,
    input  logic [31:0]     jump_target,
    input  logic [31:0]     reg_target,
    input  logic            push,
    input  logic            pop,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction,
    output logic [31:0]     pc_plus4,
    output logic            instr_valid,
    output logic            stack_overflow,
    output logic            stack_underflow
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_word;
    logic [XLEN-1:0] stack_top;
    logic [XLEN-1:0] raw_target_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_inc_c;
    logic            redirect_c;
    logic            fire_c;

    return_stack #(
        .DEPTH     (STACK_DEPTH),
        .WIDTH     (XLEN),
        .EMPTY_VAL (RESET_PC)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push && pc_write),
        .pop       (pop && pc_write),
        .din       (pc_plus4),
        .top       (stack_top),
        .overflow  (stack_overflow),
        .underflow (stack_underflow)
    );

    // Next-PC selection; decode requests are only honoured when not stalling.
    always_comb begin
        redirect_c   = 1'b0;
        raw_target_c = pc;
        if (pc_write) begin
            case (pc_src)
                PC_BRANCH: begin redirect_c = 1'b1; raw_target_c = branch_target; end
                PC_JUMP:   begin redirect_c = 1'b1; raw_target_c = jump_target;   end
                PC_JREG:   begin redirect_c = 1'b1; raw_target_c = reg_target;    end
                PC_RET:    begin redirect_c = 1'b1; raw_target_c = stack_top;     end
                default:   ;
            endcase
        end
        target_c = word_align(raw_target_c);
        fire_c   = imem_req && imem_ready;
        pc_inc_c = XLEN'(pc + 32'd4);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            hold_word   <= '0;
            instruction <= NOP_WORD;
            pc_plus4    <= '0;
            instr_valid <= 1'b0;
        end else begin
            // Any redirect squashes IF/ID; the fetch side is handled per state.
            if (redirect_c) begin
                instruction <= NOP_WORD;
                pc_plus4    <= '0;
                instr_valid <= 1'b0;
                pc          <= target_c;
            end

            case (state)
                ST_REQ: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_c ? target_c : pc;
                    end else if (redirect_c) begin
                        if (fire_c) begin
                            imem_addr <= target_c;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (fire_c) begin
                        if (pc_write) begin
                            instruction <= imem_rdata;
                            pc_plus4    <= pc_inc_c;
                            instr_valid <= 1'b1;
                            pc          <= pc_inc_c;
                            imem_addr   <= pc_inc_c;
                        end else begin
                            hold_word <= imem_rdata;
                            imem_req  <= 1'b0;
                            state     <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect_c) begin
                        imem_req  <= 1'b1;
                        imem_addr <= target_c;
                        state     <= ST_REQ;
                    end else if (pc_write) begin
                        instruction <= hold_word;
                        pc_plus4    <= pc_inc_c;
                        instr_valid <= 1'b1;
                        pc          <= pc_inc_c;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc_inc_c;
                        state       <= ST_REQ;
                    end
                end

                // Address stays on the stale request until its response retires.
                ST_DRAIN: begin
                    if (fire_c) begin
                        imem_addr <= redirect_c ? target_c : pc;
                        state     <= ST_REQ;
                    end
                end

                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule
